present_host_if: RTL and testbench
==================================

// Module: present_host_if
// PURPOSE
//  Host-side front end of the PRESENT core_serial engine, placed between the 8-in/8-out pin bus and the core.
//  Assembles plaintext and key from 4-bit nibble writes and launches the core via Start/Ready.
//  Captures the ciphertext and returns it byte-wise over an 8-bit output; all other time the output shows status.
// PARAMETERS
//  PT_WIDTH   64  plaintext/ciphertext width; PT_NIB = PT_WIDTH/4 = 16
//  KEY_WIDTH  80  key width; KEY_NIB = KEY_WIDTH/4 = 20
// PORTS
//  Clk_ik         in   1    single clock, all state on rising edge
//  Reset_ir       in   1    asynchronous reset, active-high
//  Addr_ib        in   2    00 idle/status, 01 command, 10 data nibble, 11 ciphertext read
//  Data_ib        in   4    command code or data nibble
//  Data_ob        out  8    Addr_ib[1]=0: status byte; Addr_ib[1]=1: ciphertext byte at RdPtr
//  PlainText_ob   out  64   to core; held stable while Busy
//  Key_ob         out  80   to core; held stable while Busy
//  Start_o        out  1    one-cycle launch pulse to core
//  Ready_i        in   1    core idle/result-valid
//  CipherText_ib  in   64   core result, valid when Ready_i rises after Start
// BEHAVIOUR
//  - Access protocol: host returns Addr_ib to 00 between accesses. AddrPrev_b is registered each cycle.
//    EntryStrobe = (AddrPrev_b==00) & (Addr_ib!=00). ExitStrobe = (AddrPrev_b==11) & (Addr_ib!=11).
//    A held address acts once; a direct 01->10 change is not an entry.
//  - Commands, on entry with Addr 01: 1 SEL_PT, 2 SEL_KEY, 3 START, 4 RD_RST, 5 CLR_ERR, 0 NOP.
//    Any other code sets Err.
//  - SEL_x: Sel<=x and clears that register's nibble counter. Register contents are kept.
//  - Nibble write, on entry with Addr 10:
//    Sel reg <= {reg[W-5:0], Data_ib}, so the first nibble ends up at the MSB after a full load.
//    Counter increments and saturates at PT_NIB/KEY_NIB. PtFull/KeyFull = counter at max.
//    With Sel=none (reset value) the write is ignored and sets Err.
//  - Read: Data_ob = CT_hold byte[RdPtr], byte 0 = [63:56] (combinational mux).
//    RdPtr (3b) increments on ExitStrobe and wraps 7->0.
//  - FSM:
//    IDLE: START with PtFull&KeyFull&Ready_i -> LAUNCH. START otherwise sets Err and stays IDLE.
//    LAUNCH: Start_o=1 for exactly one cycle -> WAIT_LO.
//    WAIT_LO: wait Ready_i==0 -> WAIT_HI.
//    WAIT_HI: on Ready_i==1, CT_hold<=CipherText_ib, Done<=1, RdPtr<=0 -> IDLE.
//    Busy = state!=IDLE.
//  - While Busy: START, SEL_x and nibble writes are rejected with Err set, and PT/key are not modified.
//    RD_RST and CLR_ERR are still accepted.
//  - Done clears on the next accepted START. Err is sticky until CLR_ERR.
//  - Status byte = {1'b0, Err, Sel[1:0], KeyFull, PtFull, Done, Busy}. Sel: 00 none, 01 PT, 10 KEY.
//  - Reset (async, any time incl. mid-operation): FSM IDLE; Start_o=0; PT, key, CT_hold, counters, RdPtr,
//    Sel, Done, Err, AddrPrev_b all 0. Data_ob then shows status 8'h00 when Addr_ib=00.
//  - Latency:
//    Start_o is high in the 2nd cycle after the START entry edge (IDLE->LAUNCH register, then pulse).
//    Done is set at the edge where Ready_i is first seen high in WAIT_HI.
// STRUCTURE
//  - present_pkg: command codes, status bit indices, Addr codes, PT_WIDTH/KEY_WIDTH defaults, FSM state enum.
//  - Sub-module present_nibble_sreg: parameterised shift register + saturating counter + Full flag;
//    instantiated twice (PT, KEY).
//  - FSM, access decode and read mux stay in the top.
// TESTING
//  - Reset mid-WAIT_HI: assert Reset_ir asynchronously ->
//    Start_o=0, status 8'h00, PtFull=0, CT_hold=0 without waiting for a clock.
//  - Load 0x0123456789ABCDEF (SEL_PT, 16 nibbles) and key 0 (SEL_KEY, 20 zero nibbles):
//    PlainText_ob=64'h0123456789ABCDEF, status 8'h2C (Sel=KEY, KeyFull, PtFull).
//  - START, model core drops Ready 1 cycle after Start_o and raises it 31 cycles later with CT=64'h1122..88:
//    Start_o one pulse, Busy until capture, then reads of bytes 0..7 = 11,22,...,88, and a 9th read = 11 (wrap).
//  - START with only 15 PT nibbles -> no Start_o, Err=1. CLR_ERR -> Err=0.
//  - Nibble write and START during Busy -> PT unchanged, no second Start_o, Err=1. Capture still completes.
//  - Holding Addr 10 for 5 clocks -> exactly one nibble shifted. Code 4'hF -> Err=1.

Source files
------------

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared constants, command codes and state types for the PRESENT host front end
package present_pkg;

   localparam int DEF_PT_WIDTH  = 64;
   localparam int DEF_KEY_WIDTH = 80;

   localparam logic [1:0] ADDR_IDLE = 2'b00;
   localparam logic [1:0] ADDR_CMD  = 2'b01;
   localparam logic [1:0] ADDR_NIB  = 2'b10;
   localparam logic [1:0] ADDR_RD   = 2'b11;

   localparam logic [3:0] CMD_NOP     = 4'd0;
   localparam logic [3:0] CMD_SEL_PT  = 4'd1;
   localparam logic [3:0] CMD_SEL_KEY = 4'd2;
   localparam logic [3:0] CMD_START   = 4'd3;
   localparam logic [3:0] CMD_RD_RST  = 4'd4;
   localparam logic [3:0] CMD_CLR_ERR = 4'd5;

   localparam int ST_BUSY     = 0;
   localparam int ST_DONE     = 1;
   localparam int ST_PT_FULL  = 2;
   localparam int ST_KEY_FULL = 3;
   localparam int ST_SEL_LO   = 4;
   localparam int ST_SEL_HI   = 5;
   localparam int ST_ERR      = 6;

   typedef enum logic [1:0] {
      SEL_NONE = 2'b00,
      SEL_PT   = 2'b01,
      SEL_KEY  = 2'b10
   } sel_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LAUNCH  = 2'd1,
      S_WAIT_LO = 2'd2,
      S_WAIT_HI = 2'd3
   } state_t;

   function automatic logic [7:0] status_byte(input logic err, input sel_t sel,
                                              input logic key_full, input logic pt_full,
                                              input logic done, input logic busy);
      return {1'b0, err, sel, key_full, pt_full, done, busy};
   endfunction

endpackage

// File: rtl/present_host_if_if.sv
// rtl/present_host_if_if.sv - pin bus and core-side signals of the PRESENT host front end
interface present_host_if_if #(
   parameter int PT_WIDTH  = 64,
   parameter int KEY_WIDTH = 80
);
   logic [1:0]           Addr_ib;
   logic [3:0]           Data_ib;
   logic [7:0]           Data_ob;
   logic [PT_WIDTH-1:0]  PlainText_ob;
   logic [KEY_WIDTH-1:0] Key_ob;
   logic                 Start_o;
   logic                 Ready_i;
   logic [PT_WIDTH-1:0]  CipherText_ib;

   modport slave (
      input  Addr_ib, Data_ib, Ready_i, CipherText_ib,
      output Data_ob, PlainText_ob, Key_ob, Start_o
   );

   modport master (
      output Addr_ib, Data_ib, Ready_i, CipherText_ib,
      input  Data_ob, PlainText_ob, Key_ob, Start_o
   );
endinterface

// File: rtl/present_nibble_sreg.sv
// rtl/present_nibble_sreg.sv - nibble-wide shift register with saturating load counter
// First nibble written lands at the MSB once WIDTH/4 nibbles have been shifted in.
module present_nibble_sreg #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic [3:0]       nib,
   output logic [WIDTH-1:0] value,
   output logic             full
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = $clog2(NIB + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
         cnt   <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (shift_en) begin
         value <= {value[WIDTH-5:0], nib};
         if (cnt != CW'(NIB))
            cnt <= cnt + 1'b1;
      end
   end

   assign full = (cnt == CW'(NIB));

endmodule

// File: rtl/present_host_if.sv
// rtl/present_host_if.sv - host front end: nibble loading, launch FSM, ciphertext readback
// Every access acts once, on the first cycle the address leaves 00.
module present_host_if
   import present_pkg::*;
#(
   parameter int PT_WIDTH  = DEF_PT_WIDTH,
   parameter int KEY_WIDTH = DEF_KEY_WIDTH
) (
   input  logic               Clk_ik,
   input  logic               Reset_ir,
   present_host_if_if.slave   bus
);
   state_t              state;
   sel_t                sel;
   logic [1:0]          addr_prev;
   logic [2:0]          rd_ptr;
   logic [PT_WIDTH-1:0] ct_hold;
   logic                done;
   logic                err;
   logic                start_q;
   logic                pt_full;
   logic                key_full;

   logic busy, entry, exit_stb, cmd_stb, nib_stb;
   logic is_sel_pt, is_sel_key, is_start, is_rd_rst, is_clr_err, is_bad;
   logic start_ok, pt_clr, key_clr, pt_shift, key_shift, err_set;
   logic [7:0] ct_byte;

   always_comb begin
      busy       = (state != S_IDLE);
      entry      = (addr_prev == ADDR_IDLE) && (bus.Addr_ib != ADDR_IDLE);
      exit_stb   = (addr_prev == ADDR_RD) && (bus.Addr_ib != ADDR_RD);
      cmd_stb    = entry && (bus.Addr_ib == ADDR_CMD);
      nib_stb    = entry && (bus.Addr_ib == ADDR_NIB);

      is_sel_pt  = cmd_stb && (bus.Data_ib == CMD_SEL_PT);
      is_sel_key = cmd_stb && (bus.Data_ib == CMD_SEL_KEY);
      is_start   = cmd_stb && (bus.Data_ib == CMD_START);
      is_rd_rst  = cmd_stb && (bus.Data_ib == CMD_RD_RST);
      is_clr_err = cmd_stb && (bus.Data_ib == CMD_CLR_ERR);
      is_bad     = cmd_stb && (bus.Data_ib > CMD_CLR_ERR);

      start_ok   = is_start && !busy && pt_full && key_full && bus.Ready_i;
      pt_clr     = is_sel_pt && !busy;
      key_clr    = is_sel_key && !busy;
      pt_shift   = nib_stb && !busy && (sel == SEL_PT);
      key_shift  = nib_stb && !busy && (sel == SEL_KEY);

      // Anything that would disturb a running operation is refused and flagged
      err_set    = is_bad
                 || (busy && (is_sel_pt || is_sel_key))
                 || (is_start && !start_ok)
                 || (nib_stb && (busy || (sel == SEL_NONE)));
   end

   present_nibble_sreg #(.WIDTH(PT_WIDTH)) u_pt (
      .clk      (Clk_ik),
      .rst      (Reset_ir),
      .clr      (pt_clr),
      .shift_en (pt_shift),
      .nib      (bus.Data_ib),
      .value    (bus.PlainText_ob),
      .full     (pt_full)
   );

   present_nibble_sreg #(.WIDTH(KEY_WIDTH)) u_key (
      .clk      (Clk_ik),
      .rst      (Reset_ir),
      .clr      (key_clr),
      .shift_en (key_shift),
      .nib      (bus.Data_ib),
      .value    (bus.Key_ob),
      .full     (key_full)
   );

   always_ff @(posedge Clk_ik or posedge Reset_ir) begin
      if (Reset_ir) begin
         state     <= S_IDLE;
         sel       <= SEL_NONE;
         addr_prev <= ADDR_IDLE;
         rd_ptr    <= 3'd0;
         ct_hold   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         addr_prev <= bus.Addr_ib;
         start_q   <= 1'b0;

         if (pt_clr)
            sel <= SEL_PT;
         else if (key_clr)
            sel <= SEL_KEY;

         if (is_clr_err)
            err <= 1'b0;
         else if (err_set)
            err <= 1'b1;

         if (is_rd_rst)
            rd_ptr <= 3'd0;
         else if (exit_stb)
            rd_ptr <= rd_ptr + 3'd1;

         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  state <= S_LAUNCH;
                  done  <= 1'b0;
               end
            end
            S_LAUNCH: begin
               start_q <= 1'b1;
               state   <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               if (!bus.Ready_i)
                  state <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               // Capture overrides a same-cycle read advance so reads restart at byte 0
               if (bus.Ready_i) begin
                  ct_hold <= bus.CipherText_ib;
                  done    <= 1'b1;
                  rd_ptr  <= 3'd0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      ct_byte = ct_hold[PT_WIDTH-1 -: 8];
      for (int i = 0; i < PT_WIDTH / 8; i++) begin
         if (rd_ptr == 3'(i))
            ct_byte = ct_hold[PT_WIDTH-1-8*i -: 8];
      end
   end

   assign bus.Start_o = start_q;
   assign bus.Data_ob = bus.Addr_ib[1] ? ct_byte
                                       : status_byte(err, sel, key_full, pt_full, done, busy);

endmodule

// File: tb/tb_present_host_if.sv
// tb/tb_present_host_if.sv - directed self-checking bench for present_host_if
module tb_present_host_if;
   logic clk;
   logic Reset_ir;
   int   checks;
   int   failures;
   int   start_pulses;
   int   core_cnt;
   logic [63:0] ct_next;
   logic [63:0] pt_val;
   logic [7:0]  exp_b;
   logic        got_done;

   present_host_if_if #(.PT_WIDTH(64), .KEY_WIDTH(80)) bus ();

   present_host_if dut (
      .Clk_ik   (clk),
      .Reset_ir (Reset_ir),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: Ready drops one cycle after Start_o and returns 31 cycles later
   always @(negedge clk) begin
      if (Reset_ir) begin
         core_cnt = 0;
         bus.Ready_i = 1'b1;
      end else if (bus.Start_o) begin
         start_pulses++;
         core_cnt = 1;
         bus.CipherText_ib = 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (core_cnt != 0) begin
         core_cnt++;
         if (core_cnt == 2)
            bus.Ready_i = 1'b0;
         if (core_cnt == 33) begin
            bus.Ready_i = 1'b1;
            bus.CipherText_ib = ct_next;
            core_cnt = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic access(input logic [1:0] addr, input logic [3:0] data);
      step();
      bus.Addr_ib = addr;
      bus.Data_ib = data;
      step();
      bus.Addr_ib = 2'b00;
      #1;
   endtask

   task automatic read_byte(input string tag, input logic [7:0] exp);
      step();
      bus.Addr_ib = 2'b11;
      #1;
      check(tag, bus.Data_ob, exp);
      step();
      bus.Addr_ib = 2'b00;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      start_pulses = 0;
      core_cnt = 0;
      ct_next = 64'h1122334455667788;
      pt_val = 64'h0123456789ABCDEF;
      Reset_ir = 1'b1;
      bus.Addr_ib = 2'b00;
      bus.Data_ib = 4'h0;
      bus.Ready_i = 1'b1;
      bus.CipherText_ib = 64'h0;
      repeat (3) step();
      Reset_ir = 1'b0;
      step();

      check("reset_status", bus.Data_ob, 8'h00);
      check("reset_start", bus.Start_o, 1'b0);
      check("reset_pt", bus.PlainText_ob, 64'h0);

      access(2'b10, 4'h3);
      check("nib_no_sel_err", bus.Data_ob, 8'h40);
      check("nib_no_sel_pt", bus.PlainText_ob, 64'h0);
      access(2'b01, 4'd5);
      check("clr_err", bus.Data_ob, 8'h00);

      access(2'b01, 4'd1);
      check("sel_pt", bus.Data_ob, 8'h10);
      for (int i = 0; i < 15; i++)
         access(2'b10, pt_val[63-4*i -: 4]);
      check("pt_15_status", bus.Data_ob, 8'h10);
      access(2'b01, 4'd3);
      repeat (4) step();
      check("start_not_full_err", bus.Data_ob, 8'h50);
      check("start_not_full_pulses", start_pulses, 0);
      access(2'b01, 4'd5);
      check("clr_err_2", bus.Data_ob, 8'h10);
      access(2'b10, pt_val[3:0]);
      check("pt_full_status", bus.Data_ob, 8'h14);
      check("pt_value", bus.PlainText_ob, 64'h0123456789ABCDEF);

      access(2'b01, 4'd2);
      check("sel_key", bus.Data_ob, 8'h24);
      step();
      bus.Addr_ib = 2'b10;
      bus.Data_ib = 4'hA;
      repeat (5) step();
      bus.Addr_ib = 2'b00;
      step();
      check("hold_one_nibble", bus.Key_ob, 80'hA);
      access(2'b01, 4'd2);
      for (int i = 0; i < 20; i++)
         access(2'b10, 4'h0);
      check("key_full_status", bus.Data_ob, 8'h2C);
      check("key_value", bus.Key_ob, 80'h0);

      // START: entry edge -> LAUNCH, pulse in the following cycle
      step();
      bus.Addr_ib = 2'b01;
      bus.Data_ib = 4'd3;
      step();
      bus.Addr_ib = 2'b00;
      #1;
      check("launch_no_pulse_yet", bus.Start_o, 1'b0);
      check("busy_status", bus.Data_ob, 8'h2D);
      step();
      check("start_pulse", bus.Start_o, 1'b1);
      step();
      check("start_pulse_end", bus.Start_o, 1'b0);

      access(2'b10, 4'h5);
      access(2'b01, 4'd3);
      check("busy_key_kept", bus.Key_ob, 80'h0);
      check("busy_pt_kept", bus.PlainText_ob, 64'h0123456789ABCDEF);
      check("busy_reject_status", bus.Data_ob, 8'h6D);

      got_done = 1'b0;
      for (int i = 0; i < 100 && !got_done; i++) begin
         step();
         got_done = bus.Data_ob[1];
      end
      check("done_reached", got_done, 1'b1);
      check("done_status", bus.Data_ob, 8'h6E);
      check("single_pulse", start_pulses, 1);
      access(2'b01, 4'd5);
      check("clr_err_3", bus.Data_ob, 8'h2E);

      for (int i = 0; i < 8; i++) begin
         exp_b = ct_next[63-8*i -: 8];
         read_byte($sformatf("ct_byte_%0d", i), exp_b);
      end
      read_byte("ct_wrap", 8'h11);

      access(2'b01, 4'hF);
      check("bad_code_err", bus.Data_ob, 8'h6E);
      access(2'b01, 4'd5);

      ct_next = 64'hCAFE_F00D_CAFE_F00D;
      access(2'b01, 4'd3);
      check("restart_done_clr", bus.Data_ob, 8'h2D);
      repeat (15) step();
      check("mid_wait_busy", bus.Data_ob, 8'h2D);
      #2;
      Reset_ir = 1'b1;
      #1;
      check("async_rst_start", bus.Start_o, 1'b0);
      check("async_rst_status", bus.Data_ob, 8'h00);
      check("async_rst_pt", bus.PlainText_ob, 64'h0);
      bus.Addr_ib = 2'b11;
      #1;
      check("async_rst_ct", bus.Data_ob, 8'h00);
      bus.Addr_ib = 2'b00;
      step();
      Reset_ir = 1'b0;
      repeat (3) step();
      check("post_rst_status", bus.Data_ob, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
